pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised, elastic successor to the single-stage signed pipeline register, used between CNN datapath stages (conv MAC → activation → pooling) in the ECG accelerator.
- Provides STAGES registered stages of WIDTH-bit signed data.
- Each stage carries a valid bit; downstream backpressure goes through a valid/ready handshake, and an empty stage collapses as a bubble.
- A synchronous flush empties the chain between ECG frames without a full reset.

Parameters:
- WIDTH, 8, data width in bits (signed).
- STAGES, 4, number of register stages; legal range 1..16.
- CW, $clog2(STAGES+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous clear of all stage valid bits and data.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  chain can accept in_data this cycle.
- in_data  input  WIDTH  signed input sample.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  signed output sample (last stage register).
- count  output  CW  number of stages currently holding valid data.

Behaviour:
- State: per stage i (0 = input side, STAGES-1 = output side), registers v[i] and d[i] (WIDTH, signed).
- Stage ready: rdy[STAGES-1] = !v[STAGES-1] || out_ready; rdy[i] = !v[i] || rdy[i+1]. This is a combinational chain from out_ready.
- in_ready = rdy[0] && !flush && !rst.
- Transfer into stage 0 occurs when in_valid && in_ready.
- Transfer from stage i to stage i+1 occurs when v[i] && rdy[i+1].
- Stage update, when rdy[i] is 1:
  - v[i] takes the incoming valid.
  - d[i] loads the incoming data only if the incoming valid is 1.
  - Otherwise d[i] holds its value.
- When rdy[i] is 0, v[i] and d[i] hold.
- Bubble collapse: an empty stage always accepts, so valid data advances past gaps even while out_ready=0. A chain with k<STAGES entries stalled at the output keeps accepting until all STAGES stages are valid.
- Latency: a sample accepted at edge N appears on out_data/out_valid after edge N+STAGES-1, i.e. STAGES cycles from in_valid to out_valid with no stall.
- Throughput: 1 sample/cycle while out_ready=1.
- Stall: while out_valid=1 && out_ready=0, out_data and out_valid are held unchanged.
- count = popcount(v). It updates registered alongside v, so it reflects post-edge state.
- Flush: at an edge with flush=1, all v cleared and all d cleared to 0.
  - Input is not accepted in the flush cycle (in_ready=0).
  - The output transfer in that cycle is still considered taken if out_valid && out_ready.
  - flush dominates any simultaneous in_valid or out_ready.
- Reset: at an edge with rst=1, all v=0 and all d=0.
  - Output values after reset: out_valid=0, out_data=0, count=0.
  - in_ready=0 while rst is high and 1 on the first cycle after release.
  - Reset mid-stream discards all in-flight data; rst has priority over flush.
- Arithmetic: none; data passes bit-exact. Sign is preserved; no extension or truncation.
- STAGES=1 degenerates to a single elastic register; the same rules apply.

Test Plan:
- Reset then stream: rst 2 cycles, then in_data=-3,5,127,-128 on consecutive cycles with out_ready=1 (WIDTH=8, STAGES=4) → out_valid rises 4 cycles after the first accept; out_data=-3,5,127,-128 back-to-back; count peaks at 4.
- Backpressure fill: out_ready=0, push 1,2,3,4,5 → in_ready=1 for the first 4 accepts, then 0; count=4; out_data=1 held. Raise out_ready → 1,2,3,4 emitted; value 5 accepted the cycle in_ready returns.
- Bubble collapse: push 10, idle 2 cycles, push 20 with out_ready=0 → both reach stages 3 and 2; count=2; in_ready stays 1.
- Flush mid-stream: 3 entries in flight; assert flush with in_valid=1, in_data=9 → next cycle count=0, out_valid=0, out_data=0; value 9 is not captured.
- Reset mid-operation: full chain stalled; pulse rst 1 cycle with flush=1 → all outputs 0; in_ready=0 during rst and 1 the cycle after.
- STAGES=1, WIDTH=16: alternate out_ready 1/0 while streaming -32768, 32767 → each value is held while out_ready=0; none dropped or duplicated; in_ready=!out_valid||out_ready.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Elastic chain of STAGES signed WIDTH-bit registers, each stage with a valid bit; latency STAGES cycles with no stall.
// Valid/ready backpressure with bubble collapse: an empty stage always accepts; flush and rst clear all stages synchronously.
module pipe_reg_chain #(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 4,
  localparam int CW     = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [CW-1:0]           count
);

  logic [STAGES-1:0]       v_q;
  logic [STAGES-1:0]       v_d;
  logic signed [WIDTH-1:0] d_q [STAGES];
  logic signed [WIDTH-1:0] d_d [STAGES];
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;

  logic [STAGES-1:0]       rdy;
  logic [STAGES-1:0]       vin;
  logic signed [WIDTH-1:0] din [STAGES];

  // Ready ripples from the output back to the input through a running term,
  // so a stage is ready when it is empty or everything ahead of it drains.
  always_comb begin : rdy_chain
    logic acc;
    acc = !v_q[STAGES-1] || out_ready;
    rdy[STAGES-1] = acc;
    for (int i = STAGES - 2; i >= 0; i--) begin
      acc    = !v_q[i] || acc;
      rdy[i] = acc;
    end
  end

  assign in_ready = rdy[0] && !flush && !rst;

  always_comb begin
    vin[0] = in_valid && in_ready;
    din[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      vin[i] = v_q[i-1];
      din[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < STAGES; i++) begin
      d_d[i] = d_q[i];
    end
    for (int i = 0; i < STAGES; i++) begin
      if (rdy[i]) begin
        v_d[i] = vin[i];
        if (vin[i]) begin
          d_d[i] = din[i];
        end
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_d = count_d + CW'(v_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign count     = count_q;

  // A stalled output must not change until it is taken.
  assert property (@(posedge clk) disable iff (rst || flush)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  assert property (@(posedge clk) disable iff (rst)
    count <= CW'(STAGES));

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Two instances (4x8-bit and 1x16-bit) driven with directed and random traffic; a queue-based model checks every cycle.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic signed [7:0] a_in_data = '0;
  logic              a_in_ready, a_out_valid;
  logic signed [7:0] a_out_data;
  logic [2:0]        a_count;

  logic               b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic signed [15:0] b_in_data = '0;
  logic               b_in_ready, b_out_valid;
  logic signed [15:0] b_out_data;
  logic [0:0]         b_count;

  pipe_reg_chain #(.WIDTH(8), .STAGES(4)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  pipe_reg_chain #(.WIDTH(16), .STAGES(1)) u_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: per instance, the ordered samples in flight with the edge each was accepted at.
  logic [15:0] q_dat [2][$];
  int unsigned q_acc [2][$];
  int unsigned last_dep [2] = '{0, 0};
  bit          cleared  [2] = '{1'b1, 1'b1};
  int unsigned stages   [2] = '{4, 1};

  task automatic cmp(input string nm, input int k, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (dut%0d, edge %0d): got %0d, expected %0d", nm, k, edge_n, act, exp);
    end
  endtask

  // A sample reaches the output STAGES-1 edges after acceptance, or at the edge
  // its predecessor leaves, whichever is later.
  task automatic mon(input int k, input bit ov, input logic [15:0] od, input int cnt,
                     input bit ir, input bit ordy, input bit fl, input bit r,
                     input logic [15:0] mask);
    int unsigned e;
    int unsigned arr;
    int          n;
    bit          exp_ov;
    e      = edge_n;
    n      = 0;
    exp_ov = 1'b0;
    for (int i = 0; i < q_acc[k].size(); i++) begin
      if (q_acc[k][i] <= e) n++;
    end
    if (n > 0) begin
      arr = q_acc[k][0] + stages[k] - 1;
      if (last_dep[k] > arr) arr = last_dep[k];
      exp_ov = (e >= arr);
    end
    cmp("count", k, cnt, n);
    cmp("out_valid", k, ov, exp_ov);
    if (exp_ov) begin
      cmp("out_data", k, od & mask, q_dat[k][0] & mask);
      cleared[k] = 1'b0;
    end else if (cleared[k]) begin
      cmp("out_data_cleared", k, od & mask, 0);
    end
    cmp("in_ready", k, ir, (!r && !fl && (n < int'(stages[k]) || ordy)));
    if (r || fl) begin
      q_acc[k].delete();
      q_dat[k].delete();
      last_dep[k] = 0;
      cleared[k]  = 1'b1;
    end else if (exp_ov && ordy) begin
      void'(q_acc[k].pop_front());
      void'(q_dat[k].pop_front());
      last_dep[k] = e + 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, a_out_valid, {8'h00, a_out_data}, int'(a_count), a_in_ready, a_out_ready,
          a_flush, a_rst, 16'h00FF);
      mon(1, b_out_valid, b_out_data, int'(b_count), b_in_ready, b_out_ready,
          b_flush, b_rst, 16'hFFFF);
    end
  end

  task automatic a_cyc(input bit v, input logic [7:0] d, input bit ordy, input bit fl, input bit r);
    @(posedge clk);
    #1;
    a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_flush = fl; a_rst = r;
    #1;
    if (a_in_valid && a_in_ready) begin
      q_acc[0].push_back(edge_n + 1);
      q_dat[0].push_back({8'h00, a_in_data});
    end
  endtask

  task automatic b_cyc(input bit v, input logic [15:0] d, input bit ordy, input bit fl,
                       input bit r, output bit took);
    @(posedge clk);
    #1;
    b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_flush = fl; b_rst = r;
    #1;
    took = b_in_valid && b_in_ready;
    if (took) begin
      q_acc[1].push_back(edge_n + 1);
      q_dat[1].push_back(b_in_data);
    end
  endtask

  task automatic run_a();
    logic signed [7:0] s_vals [4] = '{-8'sd3, 8'sd5, 8'sd127, -8'sd128};
    a_cyc(0, 8'd0, 1, 0, 1);
    chk_en = 1'b1;
    a_cyc(0, 8'd0, 1, 0, 1);
    for (int i = 0; i < 4; i++) a_cyc(1, s_vals[i], 1, 0, 0);
    repeat (6) a_cyc(0, 8'd0, 1, 0, 0);
    // Fill against a stalled output, then release.
    for (int i = 1; i <= 5; i++) a_cyc(1, 8'(i), 0, 0, 0);
    repeat (2) a_cyc(1, 8'd5, 0, 0, 0);
    a_cyc(1, 8'd5, 1, 0, 0);
    repeat (6) a_cyc(0, 8'd0, 1, 0, 0);
    // Gap between two samples must collapse while stalled.
    a_cyc(1, 8'd10, 0, 0, 0);
    repeat (2) a_cyc(0, 8'd0, 0, 0, 0);
    a_cyc(1, 8'd20, 0, 0, 0);
    repeat (4) a_cyc(0, 8'd0, 0, 0, 0);
    a_cyc(1, 8'd30, 0, 0, 0);
    a_cyc(1, 8'd9, 1, 1, 0);
    repeat (2) a_cyc(0, 8'd0, 1, 0, 0);
    // Reset with flush on a full, stalled chain.
    for (int i = 1; i <= 5; i++) a_cyc(1, 8'(40 + i), 0, 0, 0);
    a_cyc(1, 8'd55, 0, 1, 1);
    a_cyc(0, 8'd0, 0, 0, 0);
    a_cyc(1, 8'd66, 1, 0, 0);
    repeat (5) a_cyc(0, 8'd0, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      a_cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
            ($urandom % 50) == 0, ($urandom % 80) == 0);
    end
  endtask

  task automatic run_b();
    bit          took;
    int          idx;
    logic [15:0] d;
    repeat (3) b_cyc(0, 16'd0, 1, 0, 1, took);
    idx = 0;
    for (int i = 0; i < 24; i++) begin
      d = (idx % 2 == 0) ? 16'h8000 : 16'h7FFF;
      b_cyc(1, d, (i % 2) == 1, 0, 0, took);
      if (took) idx++;
    end
    for (int i = 0; i < 400; i++) begin
      b_cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 2) != 0,
            ($urandom % 40) == 0, ($urandom % 90) == 0, took);
    end
  endtask

  initial begin
    bit took;
    fork
      run_a();
      run_b();
    join
    for (int i = 0; i < 8; i++) begin
      fork
        a_cyc(0, 8'd0, 1, 0, 0);
        b_cyc(0, 16'd0, 1, 0, 0, took);
      join
    end
    @(negedge clk);
    #1;
    cmp("drain_a", 0, q_acc[0].size(), 0);
    cmp("drain_b", 1, q_acc[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
